// File: rtl/pea_pkg.sv
// pea_pkg: shared PEA dimensions, sequencer state encoding and context-count clamp
package pea_pkg;
  localparam int unsigned N = 4;
  localparam int unsigned M = 4;
  localparam int unsigned N_CFG_REGS_PE = 4;
  typedef logic [1:0] seq_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic int unsigned clamp_ctx(input int unsigned n, input int unsigned max_ctx);
    return n == 0 ? 1 : (n > max_ctx ? max_ctx : n);
  endfunction
endpackage

// File: rtl/pea_acc_window_cnt.sv
// pea_acc_window_cnt: per-PE accumulation window down counter with reload and last flag
module pea_acc_window_cnt (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        dec_i,
  output logic        is_last_o
);
  logic [31:0] cnt;
  logic [31:0] reload;
  logic [31:0] load_eff;
  assign load_eff = load_val_i == '0 ? 32'd1 : load_val_i;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt    <= '0;
      reload <= '0;
    end else if (load_i) begin
      cnt    <= load_eff;
      reload <= load_eff;
    end else if (dec_i) begin
      cnt <= cnt == 32'd1 ? reload : cnt - 32'd1;
    end
  end
  assign is_last_o = cnt == 32'd1;
endmodule

// File: rtl/pea_cfg_sequencer.sv
// pea_cfg_sequencer: steps every PE through its active contexts for a programmed number of iterations
module pea_cfg_sequencer #(
  parameter int unsigned N             = pea_pkg::N,
  parameter int unsigned M             = pea_pkg::M,
  parameter int unsigned N_CFG_REGS_PE = pea_pkg::N_CFG_REGS_PE,
  parameter int unsigned LOG_CTX       = $clog2(N_CFG_REGS_PE)
) (
  input  logic                                        clk_i,
  input  logic                                        rst_n_i,
  input  logic                                        start_i,
  input  logic [LOG_CTX:0]                            n_ctx_i,
  input  logic [31:0]                                 n_iter_i,
  input  logic                                        stall_i,
  input  logic [N-1:0][M-1:0][N_CFG_REGS_PE-1:0][31:0] reg_cfg_pea_i,
  input  logic [N-1:0][M-1:0][31:0]                   reg_acc_value_pe_i,
  output logic [N-1:0][M-1:0][31:0]                   cfg_pe_o,
  output logic [LOG_CTX-1:0]                          ctx_idx_o,
  output logic                                        cfg_valid_o,
  output logic [N-1:0][M-1:0]                         acc_last_o,
  output logic                                        busy_o,
  output logic                                        done_o
);
  import pea_pkg::*;
  seq_state_t          state;
  logic [LOG_CTX-1:0]  ctx;
  logic [LOG_CTX:0]    n_ctx_q;
  logic [31:0]         iter_cnt;
  logic [31:0]         n_iter_q;
  logic                go;
  logic                adv;
  logic                wrap;
  logic                last_iter;
  logic [N-1:0][M-1:0] is_last;
  assign go        = state == ST_IDLE && start_i;
  assign adv       = state == ST_RUN && !stall_i;
  assign wrap      = {1'b0, ctx} == n_ctx_q - (LOG_CTX+1)'(1);
  assign last_iter = iter_cnt == n_iter_q - 32'd1;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      ctx      <= '0;
      iter_cnt <= '0;
      n_ctx_q  <= '0;
      n_iter_q <= '0;
    end else if (go) begin
      state    <= n_iter_i == '0 ? ST_DONE : ST_RUN;
      ctx      <= '0;
      iter_cnt <= '0;
      n_ctx_q  <= (LOG_CTX+1)'(clamp_ctx(32'(n_ctx_i), N_CFG_REGS_PE));
      n_iter_q <= n_iter_i;
    end else if (adv) begin
      ctx      <= wrap ? '0 : ctx + LOG_CTX'(1);
      iter_cnt <= wrap ? iter_cnt + 32'd1 : iter_cnt;
      state    <= wrap && last_iter ? ST_DONE : ST_RUN;
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end
  assign busy_o      = state != ST_IDLE;
  assign done_o      = state == ST_DONE;
  assign cfg_valid_o = state == ST_RUN;
  assign ctx_idx_o   = ctx;
  assign acc_last_o  = cfg_valid_o ? is_last : '0;
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < M; c++) begin : g_col
      pea_acc_window_cnt u_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (go),
        .load_val_i (reg_acc_value_pe_i[r][c]),
        .dec_i      (adv && wrap),
        .is_last_o  (is_last[r][c])
      );
      assign cfg_pe_o[r][c] = cfg_valid_o ? reg_cfg_pea_i[r][c][ctx] : '0;
    end
  end
endmodule

// File: tb/tb_pea_cfg_sequencer.sv
// tb_pea_cfg_sequencer: randomized scenarios checked against a position-based reference model
module tb_pea_cfg_sequencer;
  import pea_pkg::*;
  localparam int LC = $clog2(N_CFG_REGS_PE);
  logic clk = 1'b0;
  logic rst_n, start, stall;
  logic [LC:0] n_ctx;
  logic [31:0] n_iter;
  logic [N-1:0][M-1:0][N_CFG_REGS_PE-1:0][31:0] cfg;
  logic [N-1:0][M-1:0][31:0] acc;
  logic [N-1:0][M-1:0][31:0] cfg_pe;
  logic [LC-1:0] ctx_idx;
  logic cfg_valid, busy, done;
  logic [N-1:0][M-1:0] acc_last;
  logic stall_at [128];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pea_cfg_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .n_ctx_i(n_ctx), .n_iter_i(n_iter),
    .stall_i(stall), .reg_cfg_pea_i(cfg), .reg_acc_value_pe_i(acc), .cfg_pe_o(cfg_pe),
    .ctx_idx_o(ctx_idx), .cfg_valid_o(cfg_valid), .acc_last_o(acc_last), .busy_o(busy), .done_o(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pattern_cfg();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        for (int k = 0; k < N_CFG_REGS_PE; k++)
          cfg[r][c][k] = (r << 12) | (c << 8) | k;
  endtask

  // Expected outputs come from the count of advances p: context p%nc, iteration p/nc.
  task automatic run_and_compare(input int nc_raw, input int ni, input int pct, input bit poke,
                                 input string tag, output int vcyc, output int dcyc,
                                 output logic [31:0] h00, output logic [31:0] h33);
    int nc, total, p, cyc, it, k;
    int unsigned alat [N][M];
    logic [N-1:0][M-1:0][31:0] ecfg;
    logic [N-1:0][M-1:0] eacc;
    bit fin;
    nc = nc_raw == 0 ? 1 : (nc_raw > N_CFG_REGS_PE ? N_CFG_REGS_PE : nc_raw);
    total = nc * ni;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        alat[r][c] = acc[r][c] == 0 ? 1 : acc[r][c];
    n_ctx = (LC+1)'(nc_raw);
    n_iter = ni;
    start = 1'b1;
    stall = 1'($urandom);
    step();
    start = 1'b0;
    n_ctx = (LC+1)'($urandom);
    n_iter = $urandom;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        acc[r][c] = $urandom_range(0, 5);
    p = 0; vcyc = 0; dcyc = 0; h00 = '0; h33 = '0; cyc = 1; fin = 0;
    while (!fin) begin
      if (cyc > 4 * total + 64) begin
        errors++; checks++;
        $display("FAIL %s timeout: got no done after %0d cycles, want done", tag, cyc);
        fin = 1;
      end else if (p < total) begin
        it = p / nc;
        k = p % nc;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < M; c++) begin
            ecfg[r][c] = cfg[r][c][k];
            eacc[r][c] = (it % alat[r][c]) == alat[r][c] - 1;
          end
        checks += 5;
        if (cfg_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s status cyc%0d: got valid=%b busy=%b done=%b want 1 1 0", tag, cyc, cfg_valid, busy, done);
        end
        if (ctx_idx !== LC'(k)) begin
          errors++;
          $display("FAIL %s ctx cyc%0d: got %0d want %0d", tag, cyc, ctx_idx, k);
        end
        if (cfg_pe !== ecfg) begin
          errors++;
          $display("FAIL %s cfg_pe cyc%0d: got %h want %h", tag, cyc, cfg_pe, ecfg);
        end
        if (acc_last !== eacc) begin
          errors++;
          $display("FAIL %s acc_last cyc%0d: got %h want %h", tag, cyc, acc_last, eacc);
        end
        if (cyc > total + 64) begin
          errors++;
          $display("FAIL %s length: got %0d valid cycles, want at most %0d", tag, cyc, total + 64);
        end
        vcyc++;
        if (it < 32 && acc_last[0][0]) h00[it] = 1'b1;
        if (it < 32 && acc_last[N-1][M-1]) h33[it] = 1'b1;
        stall = (cyc < 128 && stall_at[cyc]) || ($urandom_range(99) < pct);
        if (poke) start = 1'($urandom);
        if (!stall) p++;
      end else begin
        checks++;
        if (done !== 1'b1 || cfg_valid !== 1'b0 || busy !== 1'b1 || cfg_pe !== '0 || acc_last !== '0) begin
          errors++;
          $display("FAIL %s done cyc%0d: got done=%b valid=%b busy=%b want 1 0 1 with zero outputs", tag, cyc, done, cfg_valid, busy);
        end
        dcyc = cyc;
        start = 1'b0;
        stall = 1'($urandom);
        fin = 1;
      end
      step();
      cyc++;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got busy=%b done=%b valid=%b want 0 0 0", tag, busy, done, cfg_valid);
    end
    stall = 1'b0;
    for (int i = 0; i < 128; i++) stall_at[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; n_ctx = '0; n_iter = '0; acc = '0;
    pattern_cfg();
    for (int i = 0; i < 128; i++) stall_at[i] = 1'b0;
    repeat (3) step();
    checks++;
    if (cfg_pe !== '0 || ctx_idx !== '0 || cfg_valid !== 1'b0 || acc_last !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got valid=%b busy=%b done=%b ctx=%0d want all zero", cfg_valid, busy, done, ctx_idx);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int v, d;
    logic [31:0] h0, h3;
    pattern_cfg();
    run_and_compare(3, 2, 0, 0, "basic", v, d, h0, h3);
    checks += 2;
    if (v != 6) begin errors++; $display("FAIL basic valid_cycles: got %0d want 6", v); end
    if (d != 7) begin errors++; $display("FAIL basic done_cycle: got %0d want 7", d); end
  endtask

  task automatic test_stall();
    int v, d;
    logic [31:0] h0, h3;
    pattern_cfg();
    stall_at[2] = 1'b1; stall_at[3] = 1'b1; stall_at[4] = 1'b1;
    run_and_compare(3, 2, 0, 0, "stall", v, d, h0, h3);
    checks += 2;
    if (v != 9) begin errors++; $display("FAIL stall valid_cycles: got %0d want 9", v); end
    if (d != 10) begin errors++; $display("FAIL stall done_cycle: got %0d want 10", d); end
  endtask

  task automatic test_acc_window();
    int v, d;
    logic [31:0] h0, h3;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        acc[r][c] = $urandom_range(1, 4);
    acc[0][0] = 32'd3;
    acc[N-1][M-1] = 32'd0;
    run_and_compare(1, 6, 0, 0, "acc", v, d, h0, h3);
    checks += 2;
    if (h0 !== 32'h24) begin errors++; $display("FAIL acc00 iterations: got %h want 00000024", h0); end
    if (h3 !== 32'h3f) begin errors++; $display("FAIL acc33 iterations: got %h want 0000003f", h3); end
  endtask

  task automatic test_zero_iter();
    int v, d;
    logic [31:0] h0, h3;
    run_and_compare(2, 0, 0, 0, "zero_iter", v, d, h0, h3);
    checks += 2;
    if (v != 0) begin errors++; $display("FAIL zero_iter valid_cycles: got %0d want 0", v); end
    if (d != 1) begin errors++; $display("FAIL zero_iter done_cycle: got %0d want 1", d); end
  endtask

  task automatic test_start_and_clamp();
    int v, d;
    logic [31:0] h0, h3;
    run_and_compare(3, 3, 0, 1, "start_ignored", v, d, h0, h3);
    checks++;
    if (v != 9) begin errors++; $display("FAIL start_ignored valid_cycles: got %0d want 9", v); end
    run_and_compare(0, 3, 0, 0, "ctx_zero", v, d, h0, h3);
    checks++;
    if (v != 3) begin errors++; $display("FAIL ctx_zero valid_cycles: got %0d want 3", v); end
    run_and_compare((1 << (LC+1)) - 1, 2, 0, 0, "ctx_sat", v, d, h0, h3);
    checks++;
    if (v != 2 * N_CFG_REGS_PE) begin errors++; $display("FAIL ctx_sat valid_cycles: got %0d want %0d", v, 2 * N_CFG_REGS_PE); end
  endtask

  task automatic test_reset_midrun();
    int v, d;
    bit saw_done;
    logic [31:0] h0, h3;
    n_ctx = 2; n_iter = 4; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++;
    if (cfg_valid !== 1'b1 || ctx_idx !== LC'(1)) begin
      errors++;
      $display("FAIL midrun position: got valid=%b ctx=%0d want 1 1", cfg_valid, ctx_idx);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (cfg_pe !== '0 || ctx_idx !== '0 || cfg_valid !== 1'b0 || acc_last !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun reset: got valid=%b busy=%b done=%b ctx=%0d want all zero", cfg_valid, busy, done, ctx_idx);
    end
    rst_n = 1'b1;
    saw_done = 0;
    repeat (6) begin
      if (done) saw_done = 1;
      step();
    end
    checks++;
    if (saw_done || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun no_done: got done_seen=%0d busy=%b want 0 0", saw_done, busy);
    end
    run_and_compare(2, 4, 0, 0, "after_reset", v, d, h0, h3);
    checks++;
    if (v != 8 || d != 9) begin errors++; $display("FAIL after_reset length: got %0d/%0d want 8/9", v, d); end
  endtask

  task automatic test_random();
    int v, d;
    logic [31:0] h0, h3;
    for (int n = 0; n < 25; n++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < M; c++) begin
          acc[r][c] = $urandom_range(0, 4);
          for (int k = 0; k < N_CFG_REGS_PE; k++) cfg[r][c][k] = $urandom;
        end
      run_and_compare($urandom_range(0, (1 << (LC+1)) - 1), $urandom_range(0, 5), 30, 1, "random", v, d, h0, h3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_acc_window();
    test_zero_iter();
    test_start_and_clamp();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
